// File: rtl/run_scan_ctrl.sv
// Word-to-serial scan controller: shifts an accepted word out MSB-first,
// counts overlapping runs of ones of a programmable length and reports the result.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for a job, in_ready high
// S_SHIFT  | one bit of the latched word per cycle, detector live
// S_REPORT | result held on out_* until out_ready
module run_scan_ctrl #(
  parameter int WORD_W = 16,
  parameter int IDX_W  = $clog2(WORD_W),
  parameter int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic [3:0]        in_run_len,
  output logic              in_ready,
  output logic              ser_data,
  output logic              ser_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [CNT_W-1:0]  out_count,
  output logic [IDX_W-1:0]  out_first_idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         run_q, run_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   first_q, first_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [3:0]         run_upd;
  logic               hit_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      len_q   <= '0;
      run_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
    end
  end

  // The word register shifts left, so the bit on the wire is always its MSB.
  always_comb begin
    run_upd = word_q[WORD_W-1] ? ((run_q == 4'hF) ? run_q : run_q + 4'd1) : 4'd0;
    hit_now = (len_q != 4'd0) && (run_upd >= len_q);
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    len_d         = len_q;
    run_d         = run_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    hit_d         = hit_q;
    idx_d         = idx_q;
    in_ready      = 1'b0;
    ser_data      = 1'b0;
    ser_valid     = 1'b0;
    out_valid     = 1'b0;
    out_hit       = 1'b0;
    out_count     = '0;
    out_first_idx = '0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_word;
          len_d   = in_run_len;
          run_d   = '0;
          cnt_d   = '0;
          first_d = '1;   // all ones doubles as the "no hit" index
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = word_q[WORD_W-1];
        run_d     = run_upd;
        word_d    = {word_q[WORD_W-2:0], 1'b0};
        if (hit_now) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!hit_q) begin
            first_d = idx_q;
            hit_d   = 1'b1;
          end
        end
        if (idx_q == IDX_W'(WORD_W - 1)) begin
          state_d = S_REPORT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_REPORT: begin
        out_valid     = 1'b1;
        out_hit       = hit_q;
        out_count     = cnt_q;
        out_first_idx = first_q;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
